// File: rtl/valu_seq.sv
// valu_seq: sequential vector ALU execute stage.
// Reads two source vectors through a single register-file read port,
// computes a lane-wise result and writes it back; one instruction in flight.
module valu_seq #(
   parameter int unsigned LANES      = 4,
   parameter int unsigned VREGS      = 32,
   parameter int unsigned VREG_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          instr_valid,
   output logic                          instr_ready,
   input  logic [2:0]                    instr_op,
   input  logic [$clog2(VREGS)-1:0]      instr_vd,
   input  logic [$clog2(VREGS)-1:0]      instr_vs1,
   input  logic [$clog2(VREGS)-1:0]      instr_vs2,
   output logic                          rf_rd_valid,
   output logic [$clog2(VREGS)-1:0]      rf_rd_idx,
   input  logic [VREG_WIDTH*LANES-1:0]   rf_rd_data,
   input  logic                          rf_rd_ready,
   output logic                          rf_wr_valid,
   output logic [$clog2(VREGS)-1:0]      rf_wr_idx,
   output logic [VREG_WIDTH*LANES-1:0]   rf_wr_data,
   input  logic                          rf_wr_ready,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned IW = $clog2(VREGS);
   localparam int unsigned DW = VREG_WIDTH * LANES;
   localparam int unsigned SW = $clog2(VREG_WIDTH);

   typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WB} state_t;

   state_t            state, state_n;
   logic [2:0]        op, op_n;
   logic [IW-1:0]     vd, vd_n, vs1, vs1_n, vs2, vs2_n;
   logic [DW-1:0]     op_a, op_a_n, op_b, op_b_n, res, res_n, alu;
   logic              instr_ready_n, rd_valid_n, wr_valid_n, busy_n, done_n;
   logic [IW-1:0]     rd_idx_n, wr_idx_n;
   logic [DW-1:0]     wr_data_n;
   logic [VREG_WIDTH-1:0] lane_a, lane_b, lane_r;

   // Lane-wise ALU on the latched operands; no carries cross lanes
   always_comb begin
      alu    = '0;
      lane_a = '0;
      lane_b = '0;
      lane_r = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         lane_a = op_a[i*VREG_WIDTH +: VREG_WIDTH];
         lane_b = op_b[i*VREG_WIDTH +: VREG_WIDTH];
         case (op)
            3'd0:    lane_r = lane_a + lane_b;
            3'd1:    lane_r = lane_a - lane_b;
            3'd2:    lane_r = lane_a & lane_b;
            3'd3:    lane_r = lane_a | lane_b;
            3'd4:    lane_r = lane_a ^ lane_b;
            3'd5:    lane_r = lane_a << lane_b[SW-1:0];
            3'd6:    lane_r = lane_a >> lane_b[SW-1:0];
            default: lane_r = lane_a * lane_b;
         endcase
         alu[i*VREG_WIDTH +: VREG_WIDTH] = lane_r;
      end
   end

   // Next state plus next values of every registered output
   always_comb begin
      state_n       = state;
      op_n          = op;
      vd_n          = vd;
      vs1_n         = vs1;
      vs2_n         = vs2;
      op_a_n        = op_a;
      op_b_n        = op_b;
      res_n         = res;
      instr_ready_n = 1'b0;
      rd_valid_n    = 1'b0;
      rd_idx_n      = '0;
      wr_valid_n    = 1'b0;
      wr_idx_n      = '0;
      wr_data_n     = '0;
      done_n        = 1'b0;
      case (state)
         S_IDLE: begin
            instr_ready_n = 1'b1;
            if (instr_valid && instr_ready) begin
               op_n          = instr_op;
               vd_n          = instr_vd;
               vs1_n         = instr_vs1;
               vs2_n         = instr_vs2;
               state_n       = S_RD_A;
               instr_ready_n = 1'b0;
               rd_valid_n    = 1'b1;
               rd_idx_n      = instr_vs1;
            end
         end
         S_RD_A: begin
            rd_valid_n = 1'b1;
            rd_idx_n   = vs1;
            if (rf_rd_ready) begin
               op_a_n   = rf_rd_data;
               state_n  = S_RD_B;
               rd_idx_n = vs2;
            end
         end
         S_RD_B: begin
            rd_valid_n = 1'b1;
            rd_idx_n   = vs2;
            if (rf_rd_ready) begin
               op_b_n     = rf_rd_data;
               state_n    = S_EXEC;
               rd_valid_n = 1'b0;
               rd_idx_n   = '0;
            end
         end
         S_EXEC: begin
            res_n      = alu;
            state_n    = S_WB;
            wr_valid_n = 1'b1;
            wr_idx_n   = vd;
            wr_data_n  = alu;
         end
         S_WB: begin
            wr_valid_n = 1'b1;
            wr_idx_n   = vd;
            wr_data_n  = res;
            if (rf_wr_ready) begin
               state_n       = S_IDLE;
               wr_valid_n    = 1'b0;
               wr_idx_n      = '0;
               wr_data_n     = '0;
               done_n        = 1'b1;
               instr_ready_n = 1'b1;
            end
         end
         default: begin
            state_n       = S_IDLE;
            instr_ready_n = 1'b1;
         end
      endcase
      busy_n = (state_n != S_IDLE);
   end

   // State, datapath and output registers; reset discards any in-flight work
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         op          <= '0;
         vd          <= '0;
         vs1         <= '0;
         vs2         <= '0;
         op_a        <= '0;
         op_b        <= '0;
         res         <= '0;
         instr_ready <= 1'b1;
         rf_rd_valid <= 1'b0;
         rf_rd_idx   <= '0;
         rf_wr_valid <= 1'b0;
         rf_wr_idx   <= '0;
         rf_wr_data  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         op          <= op_n;
         vd          <= vd_n;
         vs1         <= vs1_n;
         vs2         <= vs2_n;
         op_a        <= op_a_n;
         op_b        <= op_b_n;
         res         <= res_n;
         instr_ready <= instr_ready_n;
         rf_rd_valid <= rd_valid_n;
         rf_rd_idx   <= rd_idx_n;
         rf_wr_valid <= wr_valid_n;
         rf_wr_idx   <= wr_idx_n;
         rf_wr_data  <= wr_data_n;
         busy        <= busy_n;
         done        <= done_n;
      end
   end

endmodule

// File: tb/tb_valu_seq.sv
// tb_valu_seq: self-checking bench for valu_seq with a register-file model
// and a lane-wise arithmetic reference model.
module tb_valu_seq;

   localparam int unsigned LANES = 4;
   localparam int unsigned VREGS = 32;
   localparam int unsigned VW    = 32;
   localparam int unsigned DW    = LANES * VW;

   logic          clk = 1'b0;
   logic          rst;
   logic          instr_valid;
   logic          instr_ready;
   logic [2:0]    instr_op;
   logic [4:0]    instr_vd, instr_vs1, instr_vs2;
   logic          rf_rd_valid;
   logic [4:0]    rf_rd_idx;
   logic [DW-1:0] rf_rd_data;
   logic          rf_rd_ready;
   logic          rf_wr_valid;
   logic [4:0]    rf_wr_idx;
   logic [DW-1:0] rf_wr_data;
   logic          rf_wr_ready;
   logic          busy;
   logic          done;

   logic [DW-1:0] regs [VREGS];
   logic [DW-1:0] mdl  [VREGS];
   logic          load_en = 1'b0;
   logic [4:0]    load_idx = '0;
   logic [DW-1:0] load_val = '0;

   int n_tests = 0;
   int n_fail  = 0;

   // bench-side stall configuration and observations
   int rd_stall_n = 0, wr_stall_n = 0;
   int rd_cnt = 0, rd_st = 0, wr_st = 0;
   int rd_stall_total = 0, wr_stall_total = 0;
   int wr_total = 0, done_total = 0, stab_err = 0;
   logic [4:0] rlog [$];
   logic          p_rv = 0, p_rr = 0, p_wv = 0, p_wr = 0;
   logic [4:0]    p_ri = '0, p_wi = '0;
   logic [DW-1:0] p_wd = '0;

   valu_seq #(.LANES(LANES), .VREGS(VREGS), .VREG_WIDTH(VW)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_vd(instr_vd),
      .instr_vs1(instr_vs1), .instr_vs2(instr_vs2),
      .rf_rd_valid(rf_rd_valid), .rf_rd_idx(rf_rd_idx),
      .rf_rd_data(rf_rd_data), .rf_rd_ready(rf_rd_ready),
      .rf_wr_valid(rf_wr_valid), .rf_wr_idx(rf_wr_idx),
      .rf_wr_data(rf_wr_data), .rf_wr_ready(rf_wr_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   assign rf_rd_data = regs[rf_rd_idx];

   // register file: DUT writes take priority over bench preloads
   always @(posedge clk) begin
      if (rf_wr_valid && rf_wr_ready) regs[rf_wr_idx] <= rf_wr_data;
      else if (load_en)               regs[load_idx]  <= load_val;
   end

   // ready generation, stall stability and transfer bookkeeping
   always @(negedge clk) begin
      if (p_rv && !p_rr && (!rf_rd_valid || rf_rd_idx != p_ri)) stab_err++;
      if (p_wv && !p_wr && (!rf_wr_valid || rf_wr_idx != p_wi || rf_wr_data != p_wd)) stab_err++;
      if (!rf_rd_valid && rf_rd_idx != 0) stab_err++;
      if (!rf_wr_valid && (rf_wr_idx != 0 || rf_wr_data != 0)) stab_err++;
      if (!busy) begin
         rd_cnt = 0; rd_st = 0; wr_st = 0;
      end
      rf_rd_ready = !(rf_rd_valid && rd_cnt == 0 && rd_st < rd_stall_n);
      rf_wr_ready = !(rf_wr_valid && wr_st < wr_stall_n);
      if (rf_rd_valid && !rf_rd_ready) begin rd_st++; rd_stall_total++; end
      if (rf_wr_valid && !rf_wr_ready) begin wr_st++; wr_stall_total++; end
      if (rf_rd_valid && rf_rd_ready) begin rd_cnt++; rlog.push_back(rf_rd_idx); end
      if (rf_wr_valid && rf_wr_ready) wr_total++;
      if (done) done_total++;
      p_rv = rf_rd_valid; p_rr = rf_rd_ready; p_ri = rf_rd_idx;
      p_wv = rf_wr_valid; p_wr = rf_wr_ready; p_wi = rf_wr_idx; p_wd = rf_wr_data;
   end

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference: lane-wise arithmetic straight from the opcode table
   function automatic logic [DW-1:0] model(input logic [2:0] op,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      logic [31:0]   x, y, z;
      logic [63:0]   p;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         x = a[i*32 +: 32];
         y = b[i*32 +: 32];
         case (op)
            3'd0: z = x + y;
            3'd1: z = x - y;
            3'd2: z = x & y;
            3'd3: z = x | y;
            3'd4: z = x ^ y;
            3'd5: z = x << (y % 32);
            3'd6: z = x >> (y % 32);
            default: begin p = 64'(x) * 64'(y); z = p[31:0]; end
         endcase
         r[i*32 +: 32] = z;
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] vec(input logic [31:0] l0, input logic [31:0] l1,
                                        input logic [31:0] l2, input logic [31:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   // preload one register (called at a negedge, returns at the next negedge)
   task automatic set_reg(input logic [4:0] idx, input logic [DW-1:0] val);
      load_en = 1'b1; load_idx = idx; load_val = val;
      @(negedge clk);
      load_en = 1'b0;
      mdl[idx] = val;
   endtask

   // issue one instruction and return cycles from accept edge to done
   task automatic run(input logic [2:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                      input logic [4:0] vs2, input int rs, input int ws,
                      output int lat, output logic [DW-1:0] exp);
      int g;
      exp = model(op, mdl[vs1], mdl[vs2]);
      mdl[vd] = exp;
      rd_stall_n = rs; wr_stall_n = ws;
      g = 0;
      while (!instr_ready && g < 50) begin @(negedge clk); g++; end
      instr_valid = 1'b1; instr_op = op; instr_vd = vd; instr_vs1 = vs1; instr_vs2 = vs2;
      @(negedge clk);
      instr_valid = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin @(negedge clk); lat++; end
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin : main
      int lat, w0, d0, r0, rs0, ws0, rs, ws;
      logic [DW-1:0] e, e2, prev;
      logic [2:0] op;
      logic [4:0] vd, vs1, vs2;
      logic [31:0] tab [8];
      tab[0] = 32'h80000005; tab[1] = 32'h7FFFFFFD; tab[2] = 32'h00000000;
      tab[3] = 32'h80000005; tab[4] = 32'h80000005; tab[5] = 32'h00000010;
      tab[6] = 32'h08000000; tab[7] = 32'h00000004;

      rst = 1'b1; instr_valid = 1'b0; instr_op = '0;
      instr_vd = '0; instr_vs1 = '0; instr_vs2 = '0;
      rf_rd_ready = 1'b1; rf_wr_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_instr_ready", instr_ready, 1);
      check("rst_rd_valid", rf_rd_valid, 0);
      check("rst_wr_valid", rf_wr_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_idx", rf_rd_idx, 0);
      check("rst_wr_idx", rf_wr_idx, 0);
      check("rst_wr_data", rf_wr_data, 0);
      rst = 1'b0;
      @(negedge clk);

      // ADD with lane wrap-around
      set_reg(1, vec(1, 2, 3, 32'hFFFFFFFF));
      set_reg(2, vec(10, 20, 30, 1));
      w0 = wr_total;
      run(3'd0, 5'd3, 5'd1, 5'd2, 0, 0, lat, e);
      check("add_latency", lat, 5);
      check("add_result", regs[3], vec(11, 22, 33, 0));
      check("add_writes", wr_total - w0, 1);
      check("add_ready_done", {instr_ready, done}, 2'b11);

      // every opcode on fixed operands
      set_reg(1, {4{32'h80000001}});
      set_reg(2, {4{32'h00000004}});
      for (int k = 0; k < 8; k++) begin
         run(3'(k), 5'(10 + k), 5'd1, 5'd2, 0, 0, lat, e);
         check($sformatf("op%0d_result", k), regs[10 + k], {4{tab[k]}});
         check($sformatf("op%0d_latency", k), lat, 5);
      end

      // read and write stalls
      set_reg(1, vec(5, 6, 7, 8));
      set_reg(2, vec(1, 1, 1, 1));
      w0 = wr_total; rs0 = rd_stall_total; ws0 = wr_stall_total;
      run(3'd1, 5'd20, 5'd1, 5'd2, 2, 3, lat, e);
      check("stall_latency", lat, 10);
      check("stall_result", regs[20], vec(4, 5, 6, 7));
      check("stall_writes", wr_total - w0, 1);
      check("stall_rd_cycles", rd_stall_total - rs0, 2);
      check("stall_wr_cycles", wr_stall_total - ws0, 3);

      // full aliasing of destination and both sources
      set_reg(5, {4{32'd7}});
      r0 = rlog.size();
      run(3'd0, 5'd5, 5'd5, 5'd5, 0, 0, lat, e);
      check("alias_result", regs[5], {4{32'd14}});
      check("alias_reads", rlog.size() - r0, 2);
      check("alias_idx0", rlog[r0], 5);
      check("alias_idx1", rlog[r0 + 1], 5);

      // reset while in EXEC discards the instruction
      set_reg(1, {4{32'd100}});
      set_reg(2, {4{32'd200}});
      set_reg(7, {4{32'hDEADBEEF}});
      prev = regs[7];
      w0 = wr_total; d0 = done_total;
      rd_stall_n = 0; wr_stall_n = 0;
      instr_valid = 1'b1; instr_op = 3'd0; instr_vd = 5'd7; instr_vs1 = 5'd1; instr_vs2 = 5'd2;
      @(negedge clk); instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_wr_valid", rf_wr_valid, 0);
      check("mrst_done", done, 0);
      check("mrst_ready", instr_ready, 1);
      check("mrst_busy", busy, 0);
      repeat (4) @(negedge clk);
      check("mrst_no_write", wr_total - w0, 0);
      check("mrst_no_done", done_total - d0, 0);
      check("mrst_dest", regs[7], prev);

      // back-to-back with instr_valid held high
      set_reg(1, vec(1, 2, 3, 4));
      set_reg(2, vec(3, 3, 3, 3));
      e  = model(3'd7, mdl[1], mdl[2]);
      mdl[8] = e;
      e2 = model(3'd5, mdl[8], mdl[2]);
      mdl[9] = e2;
      rd_stall_n = 0; wr_stall_n = 0;
      instr_valid = 1'b1; instr_op = 3'd7; instr_vd = 5'd8; instr_vs1 = 5'd1; instr_vs2 = 5'd2;
      @(negedge clk);
      instr_op = 3'd5; instr_vd = 5'd9; instr_vs1 = 5'd8; instr_vs2 = 5'd2;
      for (int c = 1; c <= 10; c++) begin
         if (c < 5)   check($sformatf("b2b_ready_c%0d", c), instr_ready, 0);
         if (c == 5)  check("b2b_done1", {done, instr_ready}, 2'b11);
         if (c == 6)  begin check("b2b_busy2", busy, 1); instr_valid = 1'b0; end
         if (c == 10) check("b2b_done2", done, 1);
         @(negedge clk);
      end
      check("b2b_res1", regs[8], e);
      check("b2b_res2", regs[9], e2);

      // randomized instructions with random stalls against the model
      for (int t = 0; t < 40; t++) begin
         op  = 3'($urandom_range(0, 7));
         vd  = 5'($urandom_range(0, 31));
         vs1 = 5'($urandom_range(0, 31));
         vs2 = 5'($urandom_range(0, 31));
         set_reg(vs1, {$urandom, $urandom, $urandom, $urandom});
         set_reg(vs2, {$urandom, $urandom, $urandom, $urandom});
         rs = $urandom_range(0, 2);
         ws = $urandom_range(0, 2);
         w0 = wr_total;
         run(op, vd, vs1, vs2, rs, ws, lat, e);
         check($sformatf("rnd%0d_result", t), regs[vd], e);
         check($sformatf("rnd%0d_latency", t), lat, 5 + rs + ws);
         check($sformatf("rnd%0d_writes", t), wr_total - w0, 1);
      end

      check("stability_errors", stab_err, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
